rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/rf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and writeback payload type.
//   REG_AW   : register-index width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    // Payload of one accepted writeback request.
    typedef struct packed {
        logic [REG_AW-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Register scoreboard: one busy bit per register, set on reservation,
// cleared by the register-file write, and a source-operand stall lookup.
//   clk, rst            : clock, async active-high reset
//   rsv_valid, rsv_reg  : reserve a destination register
//   clr_valid, clr_reg  : register-file write completing this cycle
//   read1, read2        : source registers of the issuing instruction
//   busy                : outstanding-write bitmap
//   stall               : a source register is busy (combinational)
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rsv_valid,
    input  logic [REG_AW-1:0]   rsv_reg,
    input  logic                clr_valid,
    input  logic [REG_AW-1:0]   clr_reg,
    input  logic [REG_AW-1:0]   read1,
    input  logic [REG_AW-1:0]   read2,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Set is applied after clear so a same-edge reservation wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && !(ZERO_PROTECT && (rsv_reg == '0))) begin
            set_mask[rsv_reg] = 1'b1;
        end
        if (clr_valid) begin
            clr_mask[clr_reg] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign stall = busy_q[read1] | busy_q[read2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter (ALU = req 0, load = req 1)
// with a round-robin priority pointer, a registered write port and a
// register scoreboard for issue-stage hazard detection.
//   clk, rst                 : clock, async active-high reset
//   v0/reg0/data0 -> rdy0    : ALU writeback request / accept (comb)
//   v1/reg1/data1 -> rdy1    : load writeback request / accept (comb)
//   write/writereg/writedata : registered register-file write port
//   rsv_valid/rsv_reg        : destination reservation from issue
//   read1/read2 -> stall     : source hazard check (comb)
//   busy                     : outstanding-write bitmap
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v0,
    input  logic [REG_AW-1:0]   reg0,
    input  logic [DATA_W-1:0]   data0,
    output logic                rdy0,
    input  logic                v1,
    input  logic [REG_AW-1:0]   reg1,
    input  logic [DATA_W-1:0]   data1,
    output logic                rdy1,
    output logic                write,
    output logic [REG_AW-1:0]   writereg,
    output logic [DATA_W-1:0]   writedata,
    input  logic                rsv_valid,
    input  logic [REG_AW-1:0]   rsv_reg,
    input  logic [REG_AW-1:0]   read1,
    input  logic [REG_AW-1:0]   read2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy
);

    logic              ptr_q, ptr_d;
    logic              write_q, write_d;
    logic [REG_AW-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    wb_req_t           acc;

    // Grant, pointer update and write-port next state.
    always_comb begin
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        ptr_d       = ptr_q;
        write_d     = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;

        if (!rst) begin
            if (v0 && v1) begin
                rdy0  = ~ptr_q;
                rdy1  = ptr_q;
                // Loser of a contended grant gets priority next time.
                ptr_d = ~ptr_q;
            end else begin
                rdy0 = v0;
                rdy1 = v1;
            end
        end

        acc = rdy1 ? wb_req_t'{idx: reg1, data: data1}
                   : wb_req_t'{idx: reg0, data: data0};

        // Writes to register 0 complete the handshake but are dropped.
        if ((rdy0 || rdy1) && !(ZERO_PROTECT && (acc.idx == '0))) begin
            write_d     = 1'b1;
            writereg_d  = acc.idx;
            writedata_d = acc.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            write_q     <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            write_q     <= write_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    assign write     = write_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;

    // Busy bits clear on the edge the register file captures the write.
    rf_scoreboard #(
        .ZERO_PROTECT (ZERO_PROTECT)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .clr_valid (write_q),
        .clr_reg   (writereg_q),
        .read1     (read1),
        .read2     (read2),
        .busy      (busy),
        .stall     (stall)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a
// randomized run checked against a behavioural model.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1, rdy0, rdy1;
    logic [4:0]  reg0, reg1;
    logic [31:0] data0, data1;
    logic        write;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        rsv_valid;
    logic [4:0]  rsv_reg, read1, read2;
    logic        stall;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.ZERO_PROTECT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .v0        (v0),
        .reg0      (reg0),
        .data0     (data0),
        .rdy0      (rdy0),
        .v1        (v1),
        .reg1      (reg1),
        .data1     (data1),
        .rdy1      (rdy1),
        .write     (write),
        .writereg  (writereg),
        .writedata (writedata),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .read1     (read1),
        .read2     (read2),
        .stall     (stall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        v0 = 0; v1 = 0; reg0 = 0; reg1 = 0; data0 = 0; data1 = 0;
        rsv_valid = 0; rsv_reg = 0; read1 = 0; read2 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        v0 = 1; reg0 = 5; data0 = 32'hDEAD;
        #2;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_rdy0 got=%b exp=0", rdy0); end
        tick();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", write); end
        total++; if (writereg !== 5'd0) begin bad++; $display("FAIL reset_writereg got=%0d exp=0", writereg); end
        total++; if (writedata !== 32'd0) begin bad++; $display("FAIL reset_writedata got=%h exp=0", writedata); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        clear_inputs();
        rst = 0;
        tick();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_nowrite got=%b exp=0", write); end
    endtask

    task automatic test_single();
        v0 = 1; reg0 = 5; data0 = 32'h1234;
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_rdy0 got=%b exp=1", rdy0); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL single_rdy1 got=%b exp=0", rdy1); end
        tick();
        v0 = 0;
        total++; if (write !== 1'b1) begin bad++; $display("FAIL single_write got=%b exp=1", write); end
        total++; if (writereg !== 5'd5) begin bad++; $display("FAIL single_writereg got=%0d exp=5", writereg); end
        total++; if (writedata !== 32'h1234) begin bad++; $display("FAIL single_writedata got=%h exp=1234", writedata); end
        tick();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL single_write_off got=%b exp=0", write); end
        total++; if (writereg !== 5'd5) begin bad++; $display("FAIL single_hold_reg got=%0d exp=5", writereg); end
        total++; if (writedata !== 32'h1234) begin bad++; $display("FAIL single_hold_data got=%h exp=1234", writedata); end
    endtask

    task automatic test_contention();
        do_reset();
        v0 = 1; reg0 = 3; data0 = 32'hA3;
        v1 = 1; reg1 = 4; data1 = 32'hB4;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL cont_first got=%b exp=10", {rdy0, rdy1}); end
        tick();
        v0 = 0;
        #1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL cont_second_rdy got=%b exp=1", rdy1); end
        total++; if ({write, writereg} !== {1'b1, 5'd3}) begin bad++; $display("FAIL cont_write3 got=%b/%0d exp=1/3", write, writereg); end
        total++; if (writedata !== 32'hA3) begin bad++; $display("FAIL cont_data3 got=%h exp=a3", writedata); end
        tick();
        v1 = 0;
        total++; if ({write, writereg} !== {1'b1, 5'd4}) begin bad++; $display("FAIL cont_write4 got=%b/%0d exp=1/4", write, writereg); end
        total++; if (writedata !== 32'hB4) begin bad++; $display("FAIL cont_data4 got=%h exp=b4", writedata); end
        // Uncontended grant left the pointer at requester 1.
        v0 = 1; v1 = 1;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL cont_ptr got=%b exp=01", {rdy0, rdy1}); end
        v0 = 0; v1 = 0;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b00) begin bad++; $display("FAIL cont_idle got=%b exp=00", {rdy0, rdy1}); end
    endtask

    task automatic test_zero_protect();
        v0 = 1; reg0 = 6; data0 = 32'hAA;
        tick();
        v0 = 0;
        v1 = 1; reg1 = 0; data1 = 7;
        rsv_valid = 1; rsv_reg = 0;
        #1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL zp_rdy1 got=%b exp=1", rdy1); end
        tick();
        v1 = 0; rsv_valid = 0;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL zp_write got=%b exp=0", write); end
        total++; if (writereg !== 5'd6) begin bad++; $display("FAIL zp_hold_reg got=%0d exp=6", writereg); end
        total++; if (writedata !== 32'hAA) begin bad++; $display("FAIL zp_hold_data got=%h exp=aa", writedata); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL zp_busy0 got=%b exp=0", busy[0]); end
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1; rsv_reg = 9;
        tick();
        rsv_valid = 0;
        total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set got=%h exp=00000200", busy); end
        read1 = 9; read2 = 0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_r1 got=%b exp=1", stall); end
        read1 = 0; read2 = 9;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_r2 got=%b exp=1", stall); end
        read2 = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_nostall got=%b exp=0", stall); end
        v0 = 1; reg0 = 9; data0 = 32'h99;
        tick();
        v0 = 0; read1 = 9;
        #1;
        total++; if ({write, busy[9], stall} !== 3'b111) begin bad++; $display("FAIL sb_during_write got=%b exp=111", {write, busy[9], stall}); end
        tick();
        total++; if ({busy[9], stall} !== 2'b00) begin bad++; $display("FAIL sb_cleared got=%b exp=00", {busy[9], stall}); end
        read1 = 0;
    endtask

    task automatic test_collision();
        rsv_valid = 1; rsv_reg = 9;
        tick();
        rsv_valid = 0;
        v0 = 1; reg0 = 9; data0 = 32'h55;
        tick();
        v0 = 0;
        rsv_valid = 1; rsv_reg = 9;
        total++; if (write !== 1'b1) begin bad++; $display("FAIL coll_write got=%b exp=1", write); end
        tick();
        rsv_valid = 0;
        total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", busy[9]); end
        v0 = 1; reg0 = 9;
        tick();
        v0 = 0;
        tick();
        total++; if (busy[9] !== 1'b0) begin bad++; $display("FAIL coll_final_clear got=%b exp=0", busy[9]); end
    endtask

    task automatic test_reset_mid();
        rsv_valid = 1; rsv_reg = 12;
        v0 = 1; reg0 = 20; data0 = 32'h20;
        v1 = 1; reg1 = 21; data1 = 32'h21;
        tick();
        rsv_valid = 0;
        v0 = 0;
        #1;
        total++; if ({write, busy[12], rdy1} !== 3'b111) begin bad++; $display("FAIL rmid_pre got=%b exp=111", {write, busy[12], rdy1}); end
        rst = 1;
        #1;
        total++; if ({write, writereg, writedata} !== 38'd0) begin bad++; $display("FAIL rmid_async got=%b/%0d/%h exp=0/0/0", write, writereg, writedata); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL rmid_busy got=%h exp=0", busy); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL rmid_rdy1 got=%b exp=0", rdy1); end
        tick();
        rst = 0; v1 = 0;
        tick();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL rmid_nowrite got=%b exp=0", write); end
        v0 = 1; v1 = 1;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL rmid_ptr got=%b exp=10", {rdy0, rdy1}); end
        clear_inputs();
        #1;
    endtask

    // Randomized traffic against a behavioural model of the grant rules,
    // the one-cycle write latency and the reservation bitmap.
    task automatic test_random();
        int          m_ptr;
        logic [31:0] m_busy;
        bit          m_write;
        logic [4:0]  m_wreg;
        logic [31:0] m_wdata;
        bit          pv[2];
        logic [4:0]  preg[2];
        logic [31:0] pdata[2];
        int          g;
        bit          exp_stall;

        do_reset();
        m_ptr = 0; m_busy = '0; m_write = 0; m_wreg = '0; m_wdata = '0;
        pv[0] = 0; pv[1] = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && ($urandom_range(2) == 0)) begin
                    pv[i]    = 1;
                    preg[i]  = 5'($urandom_range(31));
                    pdata[i] = $urandom;
                end
            end
            v0 = pv[0]; reg0 = preg[0]; data0 = pdata[0];
            v1 = pv[1]; reg1 = preg[1]; data1 = pdata[1];
            rsv_valid = ($urandom_range(3) == 0);
            rsv_reg   = 5'($urandom_range(31));
            read1     = 5'($urandom_range(31));
            read2     = 5'($urandom_range(31));
            #1;

            if (pv[0] && pv[1]) g = m_ptr;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
            else                g = -1;
            exp_stall = m_busy[read1] | m_busy[read2];

            total++; if ({rdy0, rdy1} !== {g == 0, g == 1}) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, {rdy0, rdy1}, {g == 0, g == 1}); end
            total++; if (stall !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_stall); end

            if (m_write) m_busy[m_wreg] = 1'b0;
            if (rsv_valid && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
            if (pv[0] && pv[1]) m_ptr = 1 - g;
            m_write = 0;
            if (g >= 0) begin
                if (preg[g] != 0) begin
                    m_write = 1;
                    m_wreg  = preg[g];
                    m_wdata = pdata[g];
                end
                pv[g] = 0;
            end

            tick();
            total++; if (write !== m_write) begin bad++; $display("FAIL rnd_write cyc=%0d got=%b exp=%b", cyc, write, m_write); end
            total++; if (writereg !== m_wreg) begin bad++; $display("FAIL rnd_writereg cyc=%0d got=%0d exp=%0d", cyc, writereg, m_wreg); end
            total++; if (writedata !== m_wdata) begin bad++; $display("FAIL rnd_writedata cyc=%0d got=%h exp=%h", cyc, writedata, m_wdata); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy, m_busy); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single();
        test_contention();
        test_zero_protect();
        test_scoreboard();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
